// File: rtl/line_buffer_sched_if.sv
// line_buffer_sched_if: sequencer bus; master drives start/width/height/pix_valid, slave drives pix_ready/fifo_clken/line_en/win_valid/win_x/win_y/busy/frame_done/cfg_err
interface line_buffer_sched_if #(
  parameter int NLINES = 2,
  parameter int CWIDTH = 11
);
  logic start;
  logic [CWIDTH-1:0] width;
  logic [CWIDTH-1:0] height;
  logic pix_valid;
  logic pix_ready;
  logic fifo_clken;
  logic [NLINES-1:0] line_en;
  logic win_valid;
  logic [CWIDTH-1:0] win_x;
  logic [CWIDTH-1:0] win_y;
  logic busy;
  logic frame_done;
  logic cfg_err;
  modport master (
    output start, width, height, pix_valid,
    input pix_ready, fifo_clken, line_en, win_valid, win_x, win_y, busy, frame_done, cfg_err
  );
  modport slave (
    input start, width, height, pix_valid,
    output pix_ready, fifo_clken, line_en, win_valid, win_x, win_y, busy, frame_done, cfg_err
  );
endinterface

// File: rtl/line_buffer_sched.sv
// line_buffer_sched: row-delay FIFO sequencer over a width x height frame; ports clk, rst (async high), bus (slave: frame config/pixel handshake in, FIFO enables, window strobe/coords, status out)
module line_buffer_sched #(
  parameter int NLINES = 2,
  parameter int CWIDTH = 11
) (
  input logic clk,
  input logic rst,
  line_buffer_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;
  localparam logic [CWIDTH-1:0] min_dim = CWIDTH'(NLINES + 1);
  localparam logic [CWIDTH-1:0] nl = CWIDTH'(NLINES);
  state_t state, state_nx;
  logic [CWIDTH-1:0] w, h, col, row, win_x, win_y;
  logic [NLINES-1:0] line_en, line_set;
  logic ready, accept, col_wrap, last, bad_cfg, win_hit, win_valid, cfg_err;
  assign bad_cfg = bus.width < min_dim || bus.height < min_dim;
  assign accept = bus.pix_valid & ready;
  assign col_wrap = col == w - CWIDTH'(1);
  assign last = col_wrap && row == h - CWIDTH'(1);
  assign win_hit = accept && row >= nl && col >= nl;
  assign bus.pix_ready = ready;
  assign bus.fifo_clken = accept;
  assign bus.line_en = line_en;
  assign bus.win_valid = win_valid;
  assign bus.win_x = win_x;
  assign bus.win_y = win_y;
  assign bus.cfg_err = cfg_err;
  always_comb begin
    line_set = '0;
    for (int k = 0; k < NLINES; k++) line_set[k] = row >= CWIDTH'(k);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = bus.start ? (bad_cfg ? DONE : FILL) : IDLE;
      FILL: state_nx = accept && col_wrap && row == nl - CWIDTH'(1) ? RUN : FILL;
      RUN: state_nx = accept && last ? DONE : RUN;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    ready = state == FILL || state == RUN;
    bus.busy = state != IDLE;
    bus.frame_done = state == DONE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      w <= '0;
      h <= '0;
      col <= '0;
      row <= '0;
      line_en <= '0;
      win_valid <= 1'b0;
      win_x <= '0;
      win_y <= '0;
      cfg_err <= 1'b0;
    end else begin
      if (state == IDLE && bus.start) begin
        cfg_err <= bad_cfg;
        w <= bad_cfg ? w : bus.width;
        h <= bad_cfg ? h : bus.height;
        col <= '0;
        row <= '0;
      end else if (accept) begin
        col <= col_wrap ? '0 : col + CWIDTH'(1);
        row <= last ? '0 : col_wrap ? row + CWIDTH'(1) : row;
      end
      line_en <= state == IDLE ? '0 : line_en | (accept && col_wrap ? line_set : '0);
      win_valid <= win_hit;
      if (win_hit) begin
        win_x <= col;
        win_y <= row;
      end
    end
endmodule

// File: tb/tb_line_buffer_sched.sv
// tb_line_buffer_sched: scoreboard bench for line_buffer_sched
module tb_line_buffer_sched;
  localparam int NL = 2;
  localparam int CW = 11;
  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } win_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  win_t exp_q[$];
  always #5 clk = ~clk;
  line_buffer_sched_if #(.NLINES(NL), .CWIDTH(CW)) bus ();
  line_buffer_sched #(.NLINES(NL), .CWIDTH(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic run_frame(input int w, input int h, input bit gap, input int mid_start, input int rst_at, input bit done_start);
    int n = 0;
    int cyc = 0;
    int wins = 0;
    int total = w * h;
    bit exp_win = 1'b0;
    bit vld;
    logic [NL-1:0] exp_le;
    win_t e;
    exp_q.delete();
    @(negedge clk);
    bus.start = 1'b1;
    bus.width = CW'(w);
    bus.height = CW'(h);
    bus.pix_valid = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.cfg_err !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL start_accept: cfg_err=%b busy=%b, required cfg_err=0 busy=1", bus.cfg_err, bus.busy);
    end
    forever begin
      checks++;
      if (bus.win_valid !== exp_win) begin
        errors++;
        $display("FAIL win_valid at accept %0d: got %b, required %b", n, bus.win_valid, exp_win);
      end
      if (bus.win_valid === 1'b1 && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        wins++;
        checks++;
        if (bus.win_x !== e.x || bus.win_y !== e.y) begin
          errors++;
          $display("FAIL win_xy: got (%0d,%0d), required (%0d,%0d)", bus.win_x, bus.win_y, e.x, e.y);
        end
      end
      exp_le = '0;
      for (int k = 0; k < NL; k++) exp_le[k] = (n / w) > k;
      checks++;
      if (bus.line_en !== exp_le) begin
        errors++;
        $display("FAIL line_en after %0d accepts: got %b, required %b", n, bus.line_en, exp_le);
      end
      if (n == rst_at) begin
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.pix_ready, bus.fifo_clken, bus.line_en, bus.win_valid, bus.win_x, bus.win_y, bus.busy, bus.frame_done, bus.cfg_err} !== '0) begin
          errors++;
          $display("FAIL reset_mid: outputs %h, required all zero", {bus.pix_ready, bus.fifo_clken, bus.line_en, bus.win_valid, bus.win_x, bus.win_y, bus.busy, bus.frame_done, bus.cfg_err});
        end
        @(negedge clk);
        rst = 1'b0;
        bus.pix_valid = 1'b0;
        exp_q.delete();
        return;
      end
      if (n == total) break;
      if (cyc > 4000) begin
        errors++;
        $display("FAIL timeout: %0d accepts, required %0d", n, total);
        break;
      end
      checks++;
      if (bus.pix_ready !== 1'b1 || bus.busy !== 1'b1 || bus.frame_done !== 1'b0) begin
        errors++;
        $display("FAIL run_status: ready=%b busy=%b done=%b, required 1/1/0", bus.pix_ready, bus.busy, bus.frame_done);
      end
      vld = !gap || (cyc % 2) == 0;
      bus.pix_valid = vld;
      bus.start = n == mid_start;
      if (n == mid_start) bus.width = CW'(4);
      #1;
      checks++;
      if (bus.fifo_clken !== vld) begin
        errors++;
        $display("FAIL fifo_clken: got %b, required %b", bus.fifo_clken, vld);
      end
      exp_win = 1'b0;
      if (vld) begin
        if ((n % w) >= NL && (n / w) >= NL) begin
          e.x = CW'(n % w);
          e.y = CW'(n / w);
          exp_q.push_back(e);
          exp_win = 1'b1;
        end
        n++;
      end
      @(negedge clk);
      bus.start = 1'b0;
      cyc++;
    end
    checks++;
    if (bus.frame_done !== 1'b1 || bus.pix_ready !== 1'b0) begin
      errors++;
      $display("FAIL frame_done: done=%b ready=%b, required 1/0", bus.frame_done, bus.pix_ready);
    end
    bus.pix_valid = 1'b0;
    if (done_start) begin
      bus.start = 1'b1;
      bus.width = CW'(8);
      bus.height = CW'(6);
    end
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.frame_done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL after_done: done=%b busy=%b, required 0/0", bus.frame_done, bus.busy);
    end
    checks++;
    if (wins != (w - NL) * (h - NL) || exp_q.size() != 0) begin
      errors++;
      $display("FAIL win_count: got %0d (pending %0d), required %0d", wins, exp_q.size(), (w - NL) * (h - NL));
    end
    @(negedge clk);
    checks++;
    if (bus.line_en !== '0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle: line_en=%b busy=%b, required 00/0", bus.line_en, bus.busy);
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.width = '0;
    bus.height = '0;
    bus.pix_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.pix_ready, bus.fifo_clken, bus.line_en, bus.win_valid, bus.win_x, bus.win_y, bus.busy, bus.frame_done, bus.cfg_err} !== '0) begin
      errors++;
      $display("FAIL reset: outputs %h, required all zero", {bus.pix_ready, bus.fifo_clken, bus.line_en, bus.win_valid, bus.win_x, bus.win_y, bus.busy, bus.frame_done, bus.cfg_err});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.pix_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b ready=%b, required 0/0", bus.busy, bus.pix_ready);
    end
  endtask

  task automatic test_nominal();
    run_frame(8, 6, 1'b0, -1, -1, 1'b0);
  endtask

  task automatic test_gapped();
    run_frame(8, 6, 1'b1, -1, -1, 1'b0);
  endtask

  task automatic test_cfg_err();
    @(negedge clk);
    bus.start = 1'b1;
    bus.width = CW'(2);
    bus.height = CW'(6);
    bus.pix_valid = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.cfg_err !== 1'b1 || bus.pix_ready !== 1'b0 || bus.fifo_clken !== 1'b0 || bus.frame_done !== 1'b1) begin
      errors++;
      $display("FAIL cfg_err: err=%b ready=%b clken=%b done=%b, required 1/0/0/1", bus.cfg_err, bus.pix_ready, bus.fifo_clken, bus.frame_done);
    end
    @(negedge clk);
    bus.pix_valid = 1'b0;
    checks++;
    if (bus.cfg_err !== 1'b1 || bus.frame_done !== 1'b0 || bus.busy !== 1'b0 || bus.pix_ready !== 1'b0) begin
      errors++;
      $display("FAIL cfg_err_sticky: err=%b done=%b busy=%b ready=%b, required 1/0/0/0", bus.cfg_err, bus.frame_done, bus.busy, bus.pix_ready);
    end
    run_frame(8, 6, 1'b0, -1, -1, 1'b0);
  endtask

  task automatic test_start_during_run();
    run_frame(8, 6, 1'b0, 30, -1, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_frame(8, 6, 1'b0, -1, 30, 1'b0);
    run_frame(8, 6, 1'b0, -1, -1, 1'b1);
    run_frame(3, 3, 1'b0, -1, -1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_gapped();
    test_cfg_err();
    test_start_during_run();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/line_buffer_sched.md
Name: line_buffer_sched

Overview:
- Sequencer for the cascaded row-delay FIFOs in the post-processing window stage. One instance drives NLINES line FIFOs plus the live pixel row.
- Walks a width x height frame of incoming disparity pixels.
- Generates the shared FIFO clock-enable, the per-line read enables and a registered window-valid strobe with window coordinates.
- Accepts a configurable window size and tags which outputs hold a full (NLINES+1)x(NLINES+1) neighbourhood.

Parameters:
- NLINES, 2, number of cascaded line FIFOs; window is (NLINES+1) square; legal range 1..4.
- CWIDTH, 11, width of the column/row counters and the width/height inputs.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle pulse; latches width/height and begins a frame; ignored unless IDLE.
- width  in  CWIDTH  pixels per row; sampled on start.
- height  in  CWIDTH  rows per frame; sampled on start.
- pix_valid  in  1  upstream pixel present this cycle.
- pix_ready  out  1  block accepts pixels (FILL or RUN).
- fifo_clken  out  1  clken to all line FIFOs = pix_valid & pix_ready (combinational).
- line_en  out  NLINES  per-FIFO enable; bit k set once FIFO k holds a full line.
- win_valid  out  1  registered; window centred data valid on FIFO outputs.
- win_x  out  CWIDTH  registered; column of window bottom-right pixel.
- win_y  out  CWIDTH  registered; row of window bottom-right pixel.
- busy  out  1  high from start-accept until frame_done.
- frame_done  out  1  one-cycle pulse at frame end.
- cfg_err  out  1  sticky; set when width or height < NLINES+1; cleared by next accepted start.

Behaviour:
- Reset: state=IDLE; col=0, row=0; pix_ready=0; line_en=0; win_valid=0; win_x=0; win_y=0; busy=0; frame_done=0; cfg_err=0.
- States: IDLE, FILL, RUN, DONE.
- IDLE + start:
  - If width < NLINES+1 or height < NLINES+1: cfg_err=1, go to DONE (no pixels accepted).
  - Otherwise: latch w=width, h=height, col=0, row=0, cfg_err=0, busy=1, go to FILL.
- accept = pix_valid & pix_ready. Per accept:
  - col==w-1: col=0, row=row+1.
  - Otherwise: col=col+1.
  - pix_valid low: counters hold; no bubble propagation needed.
- line_en[k] registered: set when row advances past k (row > k); cleared in IDLE.
- FILL -> RUN on the accept that wraps row from NLINES-1 to NLINES.
- RUN -> DONE on accept of pixel (col=w-1, row=h-1). The same rule applies in FILL if h==NLINES+1 is unreachable; FILL never terminates a legal frame.
- DONE: pix_ready=0; frame_done=1 for exactly one cycle; busy=0 next cycle; return to IDLE.
- Window output, registered with 1-cycle latency to match the FIFO SRAM read latency:
  - win_valid <= accept & (row >= NLINES) & (col >= NLINES).
  - win_x <= col; win_y <= row, captured on that accept.
  - win_x/win_y hold when win_valid=0.
- Arithmetic: counters CWIDTH bits unsigned; w-1 and h-1 compared at CWIDTH bits; no wrap past w-1 or h-1.
- start while busy: ignored; no relatch.
- start coincident with DONE: ignored; accepted only in IDLE, the following cycle or later.
- width/height changes mid-frame: no effect (latched copies used).
- rst mid-frame: immediate return to reset values. FIFO contents are don't-care; line_en=0 forces the next frame to refill.
- Expected window count per frame: (h-NLINES)*(w-NLINES).

Test Plan:
- Nominal frame, NLINES=2, width=8, height=6, pix_valid constant 1 → 48 accepts. First win_valid one cycle after 19th accept (col=2, row=2) with win_x=2, win_y=2. Exactly 24 win_valid pulses. Last pulse win_x=7, win_y=5. frame_done one cycle after 48th accept. busy low afterwards.
- line_en sequencing, same frame → line_en=2'b01 after 8th accept, 2'b11 after 16th accept, 2'b00 in IDLE.
- Gapped input, pix_valid alternating 1/0 on same frame → counters and fifo_clken advance only on valid cycles. Still 24 windows; timing stretched 2x.
- Config error, start with width=2, height=6 → cfg_err=1, pix_ready stays 0, frame_done pulse 1 cycle later. Next start with width=8 clears cfg_err.
- start during RUN with width=4 → ignored; frame finishes with w=8, 24 windows.
- rst asserted at accept 30 → all outputs zero same cycle. New start after release produces a full 24-window frame.
